// File: rtl/amiga_keyboard_tx_if.sv
// Key-event handshake between the keyboard matrix scanner and the KCLK/KDAT transmitter.
// A transfer happens on a clock where key_valid and key_ready are both high.
interface amiga_keyboard_tx_if;
  logic       key_valid;
  logic [6:0] key_code;
  logic       key_up;
  logic       key_ready;

  modport master (output key_valid, key_code, key_up, input  key_ready);
  modport slave  (input  key_valid, key_code, key_up, output key_ready);
endinterface

// File: rtl/amiga_keyboard_tx.sv
// Keyboard-side Amiga KCLK/KDAT transmitter: rotated/inverted 8-bit frames, host handshake, lost-sync recovery.
// Define AMIGA_KBD_POWERUP_STREAM_EN to send 0xFD/0xFE after reset before accepting keys.
module amiga_keyboard_tx #(
  parameter int BIT_CYCLES     = 573,
  parameter int HS_MIN_CYCLES  = 29,
  parameter int TIMEOUT_CYCLES = 4095000
) (
  input  logic               CLK,
  input  logic               _RST,
  amiga_keyboard_tx_if.slave key,
  output logic               KCLK_OE,
  output logic               KDAT_OE,
  input  logic               KDAT_IN,
  output logic               SYNC_LOST
);
  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int RW = (HS_MIN_CYCLES > 1) ? $clog2(HS_MIN_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(HS_MIN_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    POWERUP, IDLE, SETUP, CLKLO, CLKHI, WAIT_HS, HS_END, RESYNC
  } state_t;

`ifdef AMIGA_KBD_POWERUP_STREAM_EN
  localparam state_t RESET_STATE = POWERUP;
  localparam logic   PU_PENDING  = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   PU_PENDING  = 1'b0;
`endif

  function automatic logic [7:0] rotate_code(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  state_t          state;
  logic [BW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      sr;
  logic [7:0]      held;
  logic [RW-1:0]   run;
  logic [TW-1:0]   elapsed;
  logic            pend_fd, pend_fe, pend_f9, pend_rt;
  logic            resyncing;
  logic            ready_q;
  logic            kdat_s1, kdat_s2;
  logic [7:0]      next_byte, next_rot, key_rot;
  logic            next_have;
  logic            transfer, bit_end, launch;

  assign key.key_ready = ready_q;
  assign transfer      = key.key_valid & ready_q;
  assign bit_end       = (cnt == BIT_LAST);
  assign launch        = (state == POWERUP) || ((state == HS_END) && kdat_s2);

  // Queue order: power-up codes, lost-sync marker, then retransmit of the held event.
  always_comb begin
    next_have = 1'b1;
    next_byte = held;
    if (pend_fd)       next_byte = 8'hFD;
    else if (pend_fe)  next_byte = 8'hFE;
    else if (pend_f9)  next_byte = 8'hF9;
    else if (!pend_rt) next_have = 1'b0;
    next_rot = rotate_code(next_byte);
    key_rot  = rotate_code({key.key_up, key.key_code});
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      held      <= '0;
      run       <= '0;
      elapsed   <= '0;
      pend_fd   <= PU_PENDING;
      pend_fe   <= PU_PENDING;
      pend_f9   <= 1'b0;
      pend_rt   <= 1'b0;
      resyncing <= 1'b0;
      ready_q   <= 1'b0;
      KCLK_OE   <= 1'b0;
      KDAT_OE   <= 1'b0;
      SYNC_LOST <= 1'b0;
      kdat_s1   <= 1'b1;
      kdat_s2   <= 1'b1;
    end else begin
      kdat_s1   <= KDAT_IN;
      kdat_s2   <= kdat_s1;
      SYNC_LOST <= 1'b0;
      case (state)
        POWERUP, HS_END: begin
          if (launch) begin
            if (next_have) begin
              state   <= SETUP;
              sr      <= next_rot;
              KDAT_OE <= next_rot[7];
              cnt     <= '0;
              bit_idx <= '0;
              if (pend_fd || pend_fe) held <= next_byte;
              if (pend_fd)      pend_fd <= 1'b0;
              else if (pend_fe) pend_fe <= 1'b0;
              else if (pend_f9) pend_f9 <= 1'b0;
              else              pend_rt <= 1'b0;
            end else begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (transfer) begin
            state   <= SETUP;
            ready_q <= 1'b0;
            held    <= {key.key_up, key.key_code};
            sr      <= key_rot;
            KDAT_OE <= key_rot[7];
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP, RESYNC: begin
          if (bit_end) begin
            state   <= CLKLO;
            KCLK_OE <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLKLO: begin
          if (bit_end) begin
            state   <= CLKHI;
            KCLK_OE <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLKHI: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= WAIT_HS;
              KDAT_OE <= 1'b0;
              run     <= '0;
              elapsed <= '0;
            end else begin
              state   <= SETUP;
              bit_idx <= bit_idx + 3'd1;
              sr      <= {sr[6:0], 1'b0};
              KDAT_OE <= sr[6];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Handshake is tested before the timeout so it wins a same-cycle tie.
        WAIT_HS: begin
          if (!kdat_s2 && (run == RUN_LAST)) begin
            state <= HS_END;
            if (resyncing) begin
              pend_f9   <= 1'b1;
              pend_rt   <= 1'b1;
              resyncing <= 1'b0;
            end
          end else if (elapsed == TMO_LAST) begin
            state     <= RESYNC;
            SYNC_LOST <= 1'b1;
            KDAT_OE   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= 3'd7;
            resyncing <= 1'b1;
          end else begin
            elapsed <= elapsed + 1'b1;
            run     <= kdat_s2 ? '0 : run + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
